axicb_mst_switch_wr: RTL and testbench
======================================

# axicb_mst_switch_wr

Per-slave write-path switch: it merges the write traffic that every master-side slave switch routes to one slave agent and sends it out on that slave's single AXI write interface. It sits directly downstream of the per-master write switches. It arbitrates write-address requests round-robin across masters and steers write data in granted-address order. It routes each write response back to the issuing master by ID.

## Interface
- AXI_ADDR_W, 8, address width; address sits in the AW channel LSBs.
- AXI_ID_W, 8, ID width; in the AW channel the ID sits directly above the address, and in the B channel it occupies the LSBs.
- MST_NB, 4, number of masters (fixed 4).
- MST0_ID_MASK..MST3_ID_MASK, 'h10/'h20/'h40/'h80, a response belongs to master i when (bid & MSTi_ID_MASK) != 0; lowest index wins.
- WFIFO_DEPTH_LOG2, 8, log2 depth of the write-order FIFO.
- AWCH_W, WCH_W, BCH_W, 8, concatenated channel widths.
- Ports:
- aclk  in  1  clock.
- aresetn  in  1  asynchronous active-low reset.
- srst  in  1  synchronous active-high reset; same effect as aresetn.
- i_awvalid/i_awready  in/out  MST_NB  per-master AW handshake.
- i_awch  in  MST_NB*AWCH_W  per-master AW payload.
- i_wvalid/i_wready/i_wlast  in/out/in  MST_NB  per-master W handshake.
- i_wch  in  MST_NB*WCH_W  per-master W payload.
- i_bvalid/i_bready  out/in  MST_NB  per-master B handshake.
- i_bch  out  BCH_W  B payload, broadcast to all masters.
- o_awvalid/o_awready  out/in  1  AW handshake to slave.
- o_awch  out  AWCH_W  granted AW payload.
- o_wvalid/o_wready/o_wlast  out/in/out  1  W handshake to slave.
- o_wch  out  WCH_W  selected W payload.
- o_bvalid/o_bready  in/out  1  B handshake from slave.
- o_bch  in  BCH_W  B payload.
- o_bdrop  out  1  one-cycle pulse when an unmatched response is discarded.

## Operation
- AW arbitration: requests = i_awvalid. The grant is combinational from the requests and a registered round-robin pointer. The pointer advances past the winner on o_awvalid & o_awready.
- AW lock: once o_awvalid rises without o_awready, a registered lock holds the grant until the handshake completes. Payload and valid stay stable per AXI.
- o_awvalid = i_awvalid[gnt] & !wfifo_full. i_awready[gnt] = o_awready & !wfifo_full; all other i_awready bits are 0. o_awch = i_awch[gnt].
- W ordering: every AW handshake pushes the one-hot grant into the write-order FIFO. The FIFO head selects the W source.
  - o_wvalid = !empty & i_wvalid[head]; i_wready[head] = !empty & o_wready.
  - o_wlast and o_wch are muxed from the head master.
  - The FIFO pops on o_wvalid & o_wready & o_wlast.
- B routing: the target is the lowest i with (o_bch[AXI_ID_W-1:0] & MSTi_ID_MASK) != 0.
  - i_bvalid[tgt] = o_bvalid; o_bready = i_bready[tgt]; i_bch = o_bch.
- Reset/srst values: all valids, readies and o_bdrop are 0. The FIFO is empty, the pointer selects master 0 and the lock is clear. Reset mid-burst abandons the transaction.

## Timing
- AW and B paths have zero latency (combinational).
- W data for an address can pass at the earliest one cycle after its AW handshake, because the FIFO has no pass-through. W arriving earlier is stalled.
- FIFO full blocks AW only; W continues to drain. FIFO empty drives i_wready low for all masters.
- A simultaneous push and pop leaves the count unchanged. At count = 2^WFIFO_DEPTH_LOG2 the FIFO is full.
- Multi-beat bursts keep the head master until wlast; beats from other masters never interleave.

## Configuration
- AXICB_BCH_DROP_EN.
- Defined: a response that matches no mask is accepted (o_bready = 1) and discarded, and o_bdrop pulses for one cycle.
- Undefined: an unmatched response gets o_bready = 0 and stalls the B channel. o_bdrop is tied to 0.

## Structure
- Shared package axicb_pkg holds the MST_NB constant and the default ID masks.
- Sub-modules:
  - axicb_round_robin instance for AW arbitration (enable = AW handshake, req = i_awvalid).
  - axicb_scfifo instance (PASS_THRU 0, DATA_WIDTH MST_NB) for write order.

## Test plan
- Masters 0 and 2 request AW at the same time from reset -> master 0 is granted, then master 2 on the next handshake; o_awch matches each source.
- Master 1 sends AW, and o_awready is held low 5 cycles while master 3 requests -> grant and o_awch stay on master 1 until the handshake.
- Master 0 issues a 4-beat AW, then master 1 a 2-beat AW; both W streams are presented together -> o_wch delivers 4 master-0 beats then 2 master-1 beats, and the FIFO is empty after.
- Slave returns bid 'h21 -> only i_bvalid[1] rises; i_bready[1] completes the handshake.
- Fill the FIFO with 256 AWs and no W -> o_awvalid and i_awready stay low. One wlast beat unblocks exactly one AW.
- bid 'h01 with AXICB_BCH_DROP_EN -> o_bready = 1 and o_bdrop pulses once. Without the macro -> o_bready stays 0 and no i_bvalid rises.

Source files
------------

// File: rtl/axicb_pkg.sv
// Shared constants for the AXI crossbar switch slice.
package axicb_pkg;

    // Number of master-side ports merged by a slave switch
    localparam int MST_NB = 4;

    // Default ID masks: master i owns responses whose ID has bit (4+i) set
    localparam logic [MST_NB-1:0][7:0] MST_ID_MASK_DEF = {8'h80, 8'h40, 8'h20, 8'h10};

    // Isolate the lowest set bit of a request vector (lowest index wins)
    function automatic logic [MST_NB-1:0] lowest_one(input logic [MST_NB-1:0] v);
        lowest_one = v & (~v + MST_NB'(1));
    endfunction

endpackage

// File: rtl/axicb_round_robin.sv
// Round-robin arbiter with a registered pointer and a grant lock.
// The grant is combinational; 'hold' freezes it on the next cycle so a
// presented-but-unaccepted request keeps its grant. REQ_NB must be a power of 2.
module axicb_round_robin
    import axicb_pkg::*;
#(
    parameter int REQ_NB = MST_NB
)(
    input  logic              aclk,
    input  logic              aresetn,
    input  logic              srst,
    input  logic              en,
    input  logic              hold,
    input  logic [REQ_NB-1:0] req,
    output logic [REQ_NB-1:0] gnt
);

    localparam int PW = (REQ_NB > 1) ? $clog2(REQ_NB) : 1;

    logic [PW-1:0] ptr, win, win_q, cur, idx;
    logic          lock, found;

    // First requester at or after the pointer, scanning with wrap-around
    always_comb begin
        win   = ptr;
        found = 1'b0;
        idx   = '0;
        for (int k = REQ_NB - 1; k >= 0; k--) begin
            idx = ptr + PW'(k);
            if (req[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
    end

    assign cur = lock ? win_q : win;
    assign gnt = (lock | found) ? (REQ_NB'(1) << cur) : '0;

    // Pointer moves past the winner on each accepted request; lock tracks stalls
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            ptr   <= '0;
            win_q <= '0;
            lock  <= 1'b0;
        end else if (srst) begin
            ptr   <= '0;
            win_q <= '0;
            lock  <= 1'b0;
        end else begin
            lock  <= hold;
            win_q <= cur;
            if (en) ptr <= cur + PW'(1);
        end
    end

endmodule

// File: rtl/axicb_scfifo.sv
// Single-clock FIFO. With PASS_THRU=0 data written in one cycle is visible
// at the head only from the next cycle; PASS_THRU=1 bypasses an empty FIFO.
module axicb_scfifo #(
    parameter int PASS_THRU  = 0,
    parameter int DEPTH_LOG2 = 8,
    parameter int DATA_WIDTH = 4
)(
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  srst,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  pull,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  empty,
    output logic                  full
);

    localparam int DEPTH = 2 ** DEPTH_LOG2;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
    logic [DEPTH_LOG2:0]   cnt;
    logic                  wr_en, rd_en, mem_empty;

    // Count never exceeds DEPTH, so its MSB alone flags full
    assign full      = cnt[DEPTH_LOG2];
    assign mem_empty = (cnt == '0);
    assign rd_en     = pull & !mem_empty;

    generate
        if (PASS_THRU != 0) begin : g_pass
            assign wr_en    = push & !full & !(mem_empty & pull);
            assign empty    = mem_empty & !push;
            assign data_out = mem_empty ? data_in : mem[rd_ptr];
        end else begin : g_reg
            assign wr_en    = push & !full;
            assign empty    = mem_empty;
            assign data_out = mem[rd_ptr];
        end
    endgenerate

    // Storage array, no reset needed: only read below the count
    always_ff @(posedge aclk) begin
        if (wr_en) mem[wr_ptr] <= data_in;
    end

    // Pointers and occupancy; push+pop together keeps the count
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (srst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, rd_en})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/axicb_mst_switch_wr.sv
// Per-slave write switch: round-robin AW merge, W steered in AW grant order
// through a write-order FIFO, B routed back to the owner by ID mask.
// Optional AXICB_BCH_DROP_EN: accept and discard responses matching no master.
module axicb_mst_switch_wr
    import axicb_pkg::*;
#(
    parameter int                  AXI_ADDR_W       = 8,
    parameter int                  AXI_ID_W         = 8,
    parameter logic [AXI_ID_W-1:0] MST0_ID_MASK     = AXI_ID_W'(MST_ID_MASK_DEF[0]),
    parameter logic [AXI_ID_W-1:0] MST1_ID_MASK     = AXI_ID_W'(MST_ID_MASK_DEF[1]),
    parameter logic [AXI_ID_W-1:0] MST2_ID_MASK     = AXI_ID_W'(MST_ID_MASK_DEF[2]),
    parameter logic [AXI_ID_W-1:0] MST3_ID_MASK     = AXI_ID_W'(MST_ID_MASK_DEF[3]),
    parameter int                  WFIFO_DEPTH_LOG2 = 8,
    parameter int                  AWCH_W           = 8,
    parameter int                  WCH_W            = 8,
    parameter int                  BCH_W            = 8
)(
    input  logic                     aclk,
    input  logic                     aresetn,
    input  logic                     srst,
    input  logic [MST_NB-1:0]        i_awvalid,
    output logic [MST_NB-1:0]        i_awready,
    input  logic [MST_NB*AWCH_W-1:0] i_awch,
    input  logic [MST_NB-1:0]        i_wvalid,
    output logic [MST_NB-1:0]        i_wready,
    input  logic [MST_NB-1:0]        i_wlast,
    input  logic [MST_NB*WCH_W-1:0]  i_wch,
    output logic [MST_NB-1:0]        i_bvalid,
    input  logic [MST_NB-1:0]        i_bready,
    output logic [BCH_W-1:0]         i_bch,
    output logic                     o_awvalid,
    input  logic                     o_awready,
    output logic [AWCH_W-1:0]        o_awch,
    output logic                     o_wvalid,
    input  logic                     o_wready,
    output logic                     o_wlast,
    output logic [WCH_W-1:0]         o_wch,
    input  logic                     o_bvalid,
    output logic                     o_bready,
    input  logic [BCH_W-1:0]         o_bch,
    output logic                     o_bdrop
);

    localparam logic [MST_NB-1:0][AXI_ID_W-1:0] ID_MASK =
        {MST3_ID_MASK, MST2_ID_MASK, MST1_ID_MASK, MST0_ID_MASK};

    logic [MST_NB-1:0]   aw_gnt, wf_head, b_hit, b_tgt;
    logic                wf_full, wf_empty, aw_hs, aw_hold, w_pop;
    logic [AWCH_W-1:0]   awch_sel;
    logic [WCH_W-1:0]    wch_sel;
    logic [AXI_ID_W-1:0] bid;

    // ---------------- AW merge ----------------
    axicb_round_robin #(.REQ_NB(MST_NB)) u_aw_arb (
        .aclk    (aclk),
        .aresetn (aresetn),
        .srst    (srst),
        .en      (aw_hs),
        .hold    (aw_hold),
        .req     (i_awvalid),
        .gnt     (aw_gnt)
    );

    assign o_awvalid = |(i_awvalid & aw_gnt) & !wf_full;
    assign i_awready = aw_gnt & {MST_NB{o_awready & !wf_full}};
    assign aw_hs     = o_awvalid & o_awready;
    assign aw_hold   = o_awvalid & !o_awready;

    // One-hot mux of the granted AW payload
    always_comb begin
        awch_sel = '0;
        for (int i = 0; i < MST_NB; i++)
            if (aw_gnt[i]) awch_sel |= i_awch[i*AWCH_W +: AWCH_W];
    end

    // Address field and any upper fields (ID, attributes) pass through as-is
    assign o_awch[AXI_ADDR_W-1:0] = awch_sel[AXI_ADDR_W-1:0];
    generate
        if (AWCH_W > AXI_ADDR_W) begin : g_aw_hi
            assign o_awch[AWCH_W-1:AXI_ADDR_W] = awch_sel[AWCH_W-1:AXI_ADDR_W];
        end
    endgenerate

    // ---------------- W ordering ----------------
    axicb_scfifo #(
        .PASS_THRU  (0),
        .DEPTH_LOG2 (WFIFO_DEPTH_LOG2),
        .DATA_WIDTH (MST_NB)
    ) u_wfifo (
        .aclk     (aclk),
        .aresetn  (aresetn),
        .srst     (srst),
        .push     (aw_hs),
        .data_in  (aw_gnt),
        .pull     (w_pop),
        .data_out (wf_head),
        .empty    (wf_empty),
        .full     (wf_full)
    );

    assign o_wvalid = !wf_empty & |(i_wvalid & wf_head);
    assign i_wready = wf_head & {MST_NB{!wf_empty & o_wready}};
    assign o_wlast  = |(i_wlast & wf_head);
    assign w_pop    = o_wvalid & o_wready & o_wlast;
    assign o_wch    = wch_sel;

    // One-hot mux of the W payload from the head master
    always_comb begin
        wch_sel = '0;
        for (int i = 0; i < MST_NB; i++)
            if (wf_head[i]) wch_sel |= i_wch[i*WCH_W +: WCH_W];
    end

    // ---------------- B routing ----------------
    assign bid   = o_bch[AXI_ID_W-1:0];
    assign b_tgt = lowest_one(b_hit);
    assign i_bch = o_bch;
    assign i_bvalid = b_tgt & {MST_NB{o_bvalid}};

    // Which masters claim the current response ID
    always_comb begin
        b_hit = '0;
        for (int i = 0; i < MST_NB; i++)
            b_hit[i] = |(bid & ID_MASK[i]);
    end

`ifdef AXICB_BCH_DROP_EN
    logic bdrop_q;
    assign o_bready = (|b_hit) ? |(i_bready & b_tgt) : 1'b1;
    assign o_bdrop  = bdrop_q;

    // Flag each discarded response for one cycle
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn)  bdrop_q <= 1'b0;
        else if (srst) bdrop_q <= 1'b0;
        else           bdrop_q <= o_bvalid & ~|b_hit;
    end
`else
    assign o_bready = |(i_bready & b_tgt);
    assign o_bdrop  = 1'b0;
`endif

endmodule

// File: tb/tb_axicb_mst_switch_wr.sv
`timescale 1ns/1ps
module tb_axicb_mst_switch_wr;

    localparam int NB = 4;
    localparam int DEPTH = 256;
`ifdef AXICB_BCH_DROP_EN
    localparam bit DROP = 1'b1;
`else
    localparam bit DROP = 1'b0;
`endif

    logic aclk = 1'b0, aresetn = 1'b0, srst = 1'b0;
    logic [NB-1:0] i_awvalid, i_awready, i_wvalid, i_wready, i_wlast, i_bvalid, i_bready;
    logic [NB-1:0][7:0] i_awch, i_wch;
    logic [7:0] i_bch, o_awch, o_wch, o_bch;
    logic o_awvalid, o_awready, o_wvalid, o_wready, o_wlast, o_bvalid, o_bready, o_bdrop;

    always #5 aclk = ~aclk;

    axicb_mst_switch_wr dut (
        .aclk(aclk), .aresetn(aresetn), .srst(srst),
        .i_awvalid(i_awvalid), .i_awready(i_awready), .i_awch(i_awch),
        .i_wvalid(i_wvalid), .i_wready(i_wready), .i_wlast(i_wlast), .i_wch(i_wch),
        .i_bvalid(i_bvalid), .i_bready(i_bready), .i_bch(i_bch),
        .o_awvalid(o_awvalid), .o_awready(o_awready), .o_awch(o_awch),
        .o_wvalid(o_wvalid), .o_wready(o_wready), .o_wlast(o_wlast), .o_wch(o_wch),
        .o_bvalid(o_bvalid), .o_bready(o_bready), .o_bch(o_bch), .o_bdrop(o_bdrop)
    );

    typedef struct { logic [7:0] d; logic l; } beat_t;
    typedef struct { logic [7:0] d; logic l; int st; int m; } exp_t;

    beat_t wq[NB][$];    // beats each master still has to drive
    beat_t pend[NB][$];  // beats per master whose AW is not yet accepted
    exp_t  expq[$];      // scoreboard: expected slave-side W beats in order

    int errors = 0, checks = 0, cyc = 0;
    int ptr = 0, lock_m = 0, cnt = 0;
    bit lock = 0, drop_prev = 0, chk_en = 0, b_fire = 0;
    logic [NB-1:0] aw_fire = '0, w_fire = '0;
    bit aw_en = 0, w_en = 0, b_en = 0;
    int aw_left = 0, aw_maxlen = 4, awr_pct = 75, wr_pct = 75;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d actual=%h expected=%h", nm, cyc, act, exp);
        end
    endtask

    task automatic issue_aw(input int m, input int len);
        beat_t bt;
        i_awvalid[m] = 1'b1;
        i_awch[m] = 8'($urandom);
        for (int b = 0; b < len; b++) begin
            bt.d = 8'($urandom);
            bt.l = (b == len - 1);
            wq[m].push_back(bt);
            pend[m].push_back(bt);
        end
    endtask

    task automatic consume();
        for (int m = 0; m < NB; m++) begin
            if (aw_fire[m]) i_awvalid[m] = 1'b0;
            if (w_fire[m]) begin
                void'(wq[m].pop_front());
                i_wvalid[m] = 1'b0;
            end
        end
        if (b_fire) o_bvalid = 1'b0;
    endtask

    task automatic step();
        @(negedge aclk);
        consume();
        for (int m = 0; m < NB; m++)
            if (aw_en && !i_awvalid[m] && aw_left > 0 && $urandom_range(0, 99) < 40) begin
                aw_left--;
                issue_aw(m, $urandom_range(1, aw_maxlen));
            end
        for (int m = 0; m < NB; m++)
            if (w_en && !i_wvalid[m] && wq[m].size() > 0 && $urandom_range(0, 99) < 60) begin
                i_wvalid[m] = 1'b1;
                i_wch[m] = wq[m][0].d;
                i_wlast[m] = wq[m][0].l;
            end
        o_awready = ($urandom_range(0, 99) < awr_pct);
        o_wready = ($urandom_range(0, 99) < wr_pct);
        i_bready = 4'($urandom);
        if (b_en && !o_bvalid && $urandom_range(0, 1) == 1) begin
            o_bvalid = 1'b1;
            o_bch = 8'($urandom) | (8'h10 << $urandom_range(0, 3));
        end
    endtask

    task automatic drain();
        int t = 0;
        bit busy;
        aw_en = 0; b_en = 0; w_en = 1; awr_pct = 100; wr_pct = 100;
        do begin
            step();
            t++;
            busy = (expq.size() > 0) || (i_awvalid != 0) || o_bvalid;
            for (int m = 0; m < NB; m++) busy |= (wq[m].size() > 0);
        end while (busy && t < 5000);
        if (busy) begin
            checks++; errors++;
            $display("FAIL drain_timeout cyc=%0d actual=busy expected=idle", cyc);
        end
    endtask

    // Monitor and reference model: evaluated mid-low-phase with inputs settled
    always @(negedge aclk) begin
        int win, hm, tgt;
        bit full, vexp, avail;
        exp_t e;
        beat_t b;
        #2;
        if (chk_en) begin
            cyc++;
            full = (cnt == DEPTH);
            // W path: FIFO head is the oldest burst accepted in an earlier cycle
            avail = (expq.size() > 0) && (expq[0].st < cyc);
            hm = avail ? expq[0].m : 0;
            chk("i_wready", i_wready, (avail && o_wready) ? (1 << hm) : 0);
            chk("o_wvalid", o_wvalid, avail && i_wvalid[hm]);
            w_fire = '0;
            if (o_wvalid && o_wready) begin
                if (expq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL w_unexpected cyc=%0d actual=%h expected=none", cyc, o_wch);
                end else begin
                    chk("o_wch", o_wch, expq[0].d);
                    chk("o_wlast", o_wlast, expq[0].l);
                    if (expq[0].l) cnt--;
                    w_fire[expq[0].m] = 1'b1;
                    void'(expq.pop_front());
                end
            end
            // AW path: round-robin from pointer, or the locked master
            win = -1;
            if (lock) win = lock_m;
            else
                for (int k = 0; k < NB; k++)
                    if (win < 0 && i_awvalid[(ptr + k) % NB]) win = (ptr + k) % NB;
            vexp = (win >= 0) && i_awvalid[win] && !full;
            chk("o_awvalid", o_awvalid, vexp);
            if (win >= 0) begin
                chk("i_awready", i_awready, (o_awready && !full) ? (1 << win) : 0);
                if (vexp) chk("o_awch", o_awch, i_awch[win]);
            end else begin
                chk("i_awready_idle", i_awready, 0);
            end
            aw_fire = '0;
            if (vexp && o_awready) begin
                aw_fire[win] = 1'b1;
                ptr = (win + 1) % NB;
                cnt++;
                while (pend[win].size() > 0) begin
                    b = pend[win].pop_front();
                    e.d = b.d; e.l = b.l; e.st = cyc; e.m = win;
                    expq.push_back(e);
                    if (b.l) break;
                end
            end
            lock = vexp && !o_awready;
            lock_m = win;
            // B path: lowest master whose mask bit appears in the ID
            tgt = -1;
            for (int i = NB - 1; i >= 0; i--) if (o_bch[4 + i]) tgt = i;
            chk("o_bdrop", o_bdrop, DROP ? drop_prev : 1'b0);
            if (o_bvalid) begin
                chk("i_bch", i_bch, o_bch);
                if (tgt >= 0) begin
                    chk("i_bvalid", i_bvalid, 1 << tgt);
                    chk("o_bready", o_bready, i_bready[tgt]);
                end else begin
                    chk("i_bvalid_unm", i_bvalid, 0);
                    chk("o_bready_unm", o_bready, DROP);
                end
            end else begin
                chk("i_bvalid_idle", i_bvalid, 0);
            end
            drop_prev = DROP && o_bvalid && (tgt < 0);
            b_fire = o_bvalid && o_bready;
        end
    end

    initial begin
        int n;
        i_awvalid = '0; i_awch = '0; i_wvalid = '0; i_wlast = '0; i_wch = '0;
        i_bready = '0; o_awready = 1'b0; o_wready = 1'b0; o_bvalid = 1'b0; o_bch = '0;
        repeat (3) @(negedge aclk);
        chk("rst_o_awvalid", o_awvalid, 0);
        chk("rst_i_awready", i_awready, 0);
        chk("rst_o_wvalid", o_wvalid, 0);
        chk("rst_i_bvalid", i_bvalid, 0);
        chk("rst_o_bdrop", o_bdrop, 0);
        aresetn = 1'b1;
        @(negedge aclk);
        // Empty write-order FIFO blocks every W source
        i_wvalid = 4'hF; i_wlast = 4'hF; o_wready = 1'b1;
        #2;
        chk("empty_i_wready", i_wready, 0);
        chk("empty_o_wvalid", o_wvalid, 0);
        i_wvalid = '0; i_wlast = '0; o_wready = 1'b0;
        chk_en = 1;

        // Masters 0 and 2 together from reset, then a lock against a new requester
        @(negedge aclk); consume();
        issue_aw(0, 4); issue_aw(2, 2); o_awready = 1'b0;
        repeat (2) begin @(negedge aclk); consume(); end
        o_awready = 1'b1;
        @(negedge aclk); consume();
        o_awready = 1'b0;
        @(negedge aclk); consume();
        issue_aw(1, 3);
        repeat (5) begin @(negedge aclk); consume(); end

        // Randomized mixed traffic
        aw_en = 1; w_en = 1; b_en = 1; aw_left = 200;
        repeat (700) step();
        drain();

        // Synchronous reset returns the pointer to master 0
        @(negedge aclk); chk_en = 0; srst = 1'b1;
        @(negedge aclk); srst = 1'b0;
        ptr = 0; lock = 0; cnt = 0; drop_prev = 0;
        aw_fire = '0; w_fire = '0; b_fire = 0; chk_en = 1;

        // Fill the FIFO with single-beat AWs and no W
        w_en = 0; aw_en = 1; aw_maxlen = 1; aw_left = DEPTH + 6; awr_pct = 100;
        repeat (500) step();
        #3;
        chk("full_o_awvalid", o_awvalid, 0);
        chk("full_i_awready", i_awready, 0);
        drain();

        // Directed B routing
        @(negedge aclk); consume();
        o_bvalid = 1'b1; o_bch = 8'h21; i_bready = 4'b1101;
        #2;
        chk("b21_i_bvalid", i_bvalid, 4'b0010);
        chk("b21_o_bready_lo", o_bready, 0);
        @(negedge aclk); consume();
        i_bready = 4'b0010;
        #2;
        chk("b21_o_bready_hi", o_bready, 1);
        @(negedge aclk); consume();
        o_bvalid = 1'b0;

        // Unmatched response
        @(negedge aclk); consume();
        o_bvalid = 1'b1; o_bch = 8'h01; i_bready = 4'hF;
        #2;
        chk("unm_o_bready", o_bready, DROP);
        chk("unm_i_bvalid", i_bvalid, 0);
        n = 0;
        repeat (DROP ? 1 : 3) @(negedge aclk);
        o_bvalid = 1'b0;
        repeat (3) begin
            #2 n += int'(o_bdrop);
            @(negedge aclk);
        end
        chk("unm_bdrop_pulses", n, DROP ? 1 : 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
